host_bus_if: RTL and testbench

- Host-side bus front end of xosera_main, directly downstream of the 8-bit 68k-style host bus (cs_n / rd_nwr / bytesel / reg_num / data).
- Synchronises the asynchronous bus into clk and detects each CS assertion.
- Produces single-cycle read/write strobes with captured register number, byte select and data byte for the register/blitter logic.
- Assembles high/low byte pairs into 16-bit word writes and returns register read data on bus_data_o.

---
 rtl/host_bus_if.sv | 113 +++++++++++
 tb/tb_host_bus_if.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/host_bus_if.sv
// host_bus_if: host bus front end - synchronises the async 8-bit host bus,
// emits one read/write strobe per chip-select assertion, pairs high/low byte
// writes into 16-bit words and returns register read data.
// Ports:
//   clk, reset_n_i                 clock, async active-low reset
//   bus_cs_n_i .. bus_data_i       raw asynchronous host bus inputs
//   bus_data_o                     registered read data byte back to the host
//   write_strobe_o, read_strobe_o  one-cycle access pulses
//   reg_num_o, bytesel_o,
//   data_byte_o                    captured access fields, held until next access
//   word_write_o, word_data_o      one-cycle pulse + held word for a completed byte pair
//   reg_rd_data_i                  register-file read value for reg_num_o
module host_bus_if #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n_i,
    input  logic        bus_cs_n_i,
    input  logic        bus_rd_nwr_i,
    input  logic        bus_bytesel_i,
    input  logic [3:0]  bus_reg_num_i,
    input  logic [7:0]  bus_data_i,
    output logic [7:0]  bus_data_o,
    output logic        write_strobe_o,
    output logic        read_strobe_o,
    output logic [3:0]  reg_num_o,
    output logic        bytesel_o,
    output logic [7:0]  data_byte_o,
    output logic        word_write_o,
    output logic [15:0] word_data_o,
    input  logic [15:0] reg_rd_data_i
);
    localparam logic [14:0] SYNC_RST = 15'h4000;

    logic [SYNC_STAGES-1:0][14:0] r_sync;
    logic [SYNC_STAGES-1:0]       r_live;
    logic                         r_cs_prev;
    logic                         r_hi_valid;
    logic [3:0]                   r_hi_reg;
    logic [7:0]                   r_hi_byte;
    logic [15:0]                  r_rd_hold;
    logic                         r_rd_pend;

    logic [14:0] w_bus_in;
    logic [14:0] w_last;
    logic        w_cs_n;
    logic        w_rd;
    logic        w_bs;
    logic [3:0]  w_reg;
    logic [7:0]  w_dat;
    logic        w_event;
    logic        w_word;

    assign w_bus_in = {bus_cs_n_i, bus_rd_nwr_i, bus_bytesel_i, bus_reg_num_i, bus_data_i};
    assign w_last   = r_sync[SYNC_STAGES-1];
    assign w_cs_n   = w_last[14];
    assign w_rd     = w_last[13];
    assign w_bs     = w_last[12];
    assign w_reg    = w_last[11:8];
    assign w_dat    = w_last[7:0];
    assign w_event  = r_cs_prev & ~w_cs_n;
    assign w_word   = w_event & ~w_rd & w_bs & r_hi_valid & (r_hi_reg == w_reg);

    // r_live marks sync stages holding real post-reset samples; cs_prev only
    // counts a high that was genuinely sampled, so the reset value of the cs
    // chain can never masquerade as a falling edge.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_sync         <= {SYNC_STAGES{SYNC_RST}};
            r_live         <= '0;
            r_cs_prev      <= 1'b0;
            r_hi_valid     <= 1'b0;
            r_hi_reg       <= '0;
            r_hi_byte      <= '0;
            r_rd_hold      <= '0;
            r_rd_pend      <= 1'b0;
            bus_data_o     <= '0;
            write_strobe_o <= 1'b0;
            read_strobe_o  <= 1'b0;
            reg_num_o      <= '0;
            bytesel_o      <= 1'b0;
            data_byte_o    <= '0;
            word_write_o   <= 1'b0;
            word_data_o    <= '0;
        end else begin
            r_sync         <= {r_sync[SYNC_STAGES-2:0], w_bus_in};
            r_live         <= {r_live[SYNC_STAGES-2:0], 1'b1};
            r_cs_prev      <= r_live[SYNC_STAGES-1] & w_cs_n;
            write_strobe_o <= w_event & ~w_rd;
            read_strobe_o  <= w_event & w_rd;
            word_write_o   <= w_word;
            r_rd_pend      <= read_strobe_o;
            if (w_event) begin
                reg_num_o   <= w_reg;
                bytesel_o   <= w_bs;
                data_byte_o <= w_dat;
            end
            if (w_word)
                word_data_o <= {r_hi_byte, w_dat};
            if (w_event && !w_rd) begin
                r_hi_valid <= ~w_bs;
                if (!w_bs) begin
                    r_hi_reg  <= w_reg;
                    r_hi_byte <= w_dat;
                end
            end
            if (read_strobe_o)
                r_rd_hold <= reg_rd_data_i;
            if (r_rd_pend)
                bus_data_o <= bytesel_o ? r_rd_hold[7:0] : r_rd_hold[15:8];
        end
    end
endmodule

// File: tb/tb_host_bus_if.sv
// tb_host_bus_if: directed bench for host_bus_if with SYNC_STAGES=2 and 3.
module tb_host_bus_if;
    logic        clk = 1'b0;
    logic        reset_n_i;
    logic        bus_cs_n_i;
    logic        bus_rd_nwr_i;
    logic        bus_bytesel_i;
    logic [3:0]  bus_reg_num_i;
    logic [7:0]  bus_data_i;
    logic [15:0] reg_rd_data_i;

    logic [7:0]  bd2, bd3;
    logic        ws2, ws3, rs2, rs3, bs2, bs3, ww2, ww3;
    logic [3:0]  rn2, rn3;
    logic [7:0]  db2, db3;
    logic [15:0] wd2, wd3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    host_bus_if #(.SYNC_STAGES(2)) u_dut2 (
        .clk(clk), .reset_n_i(reset_n_i), .bus_cs_n_i(bus_cs_n_i),
        .bus_rd_nwr_i(bus_rd_nwr_i), .bus_bytesel_i(bus_bytesel_i),
        .bus_reg_num_i(bus_reg_num_i), .bus_data_i(bus_data_i),
        .bus_data_o(bd2), .write_strobe_o(ws2), .read_strobe_o(rs2),
        .reg_num_o(rn2), .bytesel_o(bs2), .data_byte_o(db2),
        .word_write_o(ww2), .word_data_o(wd2), .reg_rd_data_i(reg_rd_data_i)
    );

    host_bus_if #(.SYNC_STAGES(3)) u_dut3 (
        .clk(clk), .reset_n_i(reset_n_i), .bus_cs_n_i(bus_cs_n_i),
        .bus_rd_nwr_i(bus_rd_nwr_i), .bus_bytesel_i(bus_bytesel_i),
        .bus_reg_num_i(bus_reg_num_i), .bus_data_i(bus_data_i),
        .bus_data_o(bd3), .write_strobe_o(ws3), .read_strobe_o(rs3),
        .reg_num_o(rn3), .bytesel_o(bs3), .data_byte_o(db3),
        .word_write_o(ww3), .word_data_o(wd3), .reg_rd_data_i(reg_rd_data_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One host access: CS low for 'hold' cycles then high for 4. Index i=0 is
    // the first edge sampling CS low (E0). Strobes/word pulses of the
    // SYNC_STAGES=2 instance are counted across the whole window.
    task automatic access(input logic rd, input logic bs, input logic [3:0] rn,
                          input logic [7:0] d, input int hold,
                          output int n_wr, output int n_rd, output int n_word,
                          output int at2, output int at3, output logic [7:0] bd4);
        n_wr = 0; n_rd = 0; n_word = 0; at2 = -1; at3 = -1; bd4 = 8'hxx;
        @(negedge clk);
        bus_rd_nwr_i = rd; bus_bytesel_i = bs; bus_reg_num_i = rn; bus_data_i = d;
        bus_cs_n_i = 1'b0;
        for (int i = 0; i < hold + 4; i++) begin
            if (i == hold) begin
                @(negedge clk);
                bus_cs_n_i = 1'b1;
            end
            @(posedge clk); #1;
            if (ws2) n_wr++;
            if (rs2) n_rd++;
            if (ws2 && rs2) n_wr += 100;
            if ((ws2 || rs2) && at2 < 0) at2 = i;
            if ((ws3 || rs3) && at3 < 0) at3 = i;
            if (ww2) n_word += ws2 ? 1 : 100;
            if (i == 4) bd4 = bd2;
        end
    endtask

    int n_wr, n_rd, n_word, at2, at3, cnt;
    logic [7:0] bd4;

    initial begin
        bus_cs_n_i = 1'b1; bus_rd_nwr_i = 1'b0; bus_bytesel_i = 1'b0;
        bus_reg_num_i = '0; bus_data_i = '0; reg_rd_data_i = '0;
        reset_n_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {bd2, ws2, rs2, rn2, bs2, db2, ww2, wd2}, '0);
        @(negedge clk);
        reset_n_i = 1'b1;
        repeat (5) @(posedge clk);

        // High then low byte to reg 4 -> word D070
        access(1'b0, 1'b0, 4'h4, 8'hD0, 8, n_wr, n_rd, n_word, at2, at3, bd4);
        chk("hi_wr_count", n_wr, 1);
        chk("hi_wr_latency", at2, 2);
        chk("hi_wr_noword", n_word, 0);
        access(1'b0, 1'b1, 4'h4, 8'h70, 8, n_wr, n_rd, n_word, at2, at3, bd4);
        chk("lo_wr_count", n_wr, 1);
        chk("lo_wr_latency", at2, 2);
        chk("lo_wr_word", n_word, 1);
        chk("word_data_d070", wd2, 16'hD070);
        chk("capture_fields", {rn2, bs2, db2}, {4'h4, 1'b1, 8'h70});
        chk("no_read_strobe", n_rd, 0);

        // Mismatched register pair gives no word, and clears the pending high byte
        access(1'b0, 1'b0, 4'h3, 8'h12, 8, n_wr, n_rd, n_word, at2, at3, bd4);
        chk("mis_hi_word", n_word, 0);
        access(1'b0, 1'b1, 4'h9, 8'h34, 8, n_wr, n_rd, n_word, at2, at3, bd4);
        chk("mis_lo_count", n_wr, 1);
        chk("mis_lo_word", n_word, 0);
        access(1'b0, 1'b1, 4'h3, 8'h56, 8, n_wr, n_rd, n_word, at2, at3, bd4);
        chk("cleared_lo_word", n_word, 0);
        chk("word_data_held", wd2, 16'hD070);

        // Reads of reg 2 with register value ABCD
        reg_rd_data_i = 16'hABCD;
        access(1'b1, 1'b0, 4'h2, 8'h00, 8, n_wr, n_rd, n_word, at2, at3, bd4);
        chk("rd_hi_count", n_rd, 1);
        chk("rd_hi_nowrite", n_wr, 0);
        chk("rd_hi_latency", at2, 2);
        chk("rd_hi_regnum", rn2, 4'h2);
        chk("rd_hi_data_e4", bd4, 8'hAB);
        access(1'b1, 1'b1, 4'h2, 8'h00, 8, n_wr, n_rd, n_word, at2, at3, bd4);
        chk("rd_lo_data_e4", bd4, 8'hCD);
        reg_rd_data_i = 16'h1357;
        access(1'b0, 1'b0, 4'h5, 8'hEE, 8, n_wr, n_rd, n_word, at2, at3, bd4);
        chk("wr_keeps_bus_data", bd2, 8'hCD);

        // A read between high and low byte does not disturb the pairing
        access(1'b0, 1'b0, 4'h6, 8'h11, 8, n_wr, n_rd, n_word, at2, at3, bd4);
        access(1'b1, 1'b1, 4'h6, 8'h00, 8, n_wr, n_rd, n_word, at2, at3, bd4);
        chk("rd_mid_pair_data", bd4, 8'h57);
        access(1'b0, 1'b1, 4'h6, 8'h22, 8, n_wr, n_rd, n_word, at2, at3, bd4);
        chk("pair_after_read", n_word, 1);
        chk("word_data_1122", wd2, 16'h1122);

        // Long CS hold gives exactly one strobe, then one more on reassert
        access(1'b0, 1'b0, 4'h1, 8'h5A, 200, n_wr, n_rd, n_word, at2, at3, bd4);
        chk("long_hold_count", n_wr + n_rd, 1);
        access(1'b0, 1'b1, 4'h1, 8'hA5, 8, n_wr, n_rd, n_word, at2, at3, bd4);
        chk("reassert_count", n_wr + n_rd, 1);

        // Reset mid-access with a pending high byte to reg 8
        access(1'b0, 1'b0, 4'h8, 8'h33, 8, n_wr, n_rd, n_word, at2, at3, bd4);
        @(negedge clk);
        bus_rd_nwr_i = 1'b0; bus_bytesel_i = 1'b1; bus_reg_num_i = 4'h8; bus_data_i = 8'h44;
        bus_cs_n_i = 1'b0;
        @(negedge clk);
        reset_n_i = 1'b0;
        repeat (3) @(negedge clk);
        reset_n_i = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ws2 || rs2 || ws3 || rs3) cnt++;
        end
        chk("rst_mid_nostrobe", cnt, 0);
        chk("rst_mid_outputs", {bd2, ws2, rs2, rn2, bs2, db2, ww2, wd2}, '0);
        @(negedge clk);
        bus_cs_n_i = 1'b1;
        repeat (4) @(posedge clk);
        access(1'b0, 1'b1, 4'h8, 8'h44, 8, n_wr, n_rd, n_word, at2, at3, bd4);
        chk("post_rst_count", n_wr, 1);
        chk("post_rst_latency", at2, 2);
        chk("post_rst_noword", n_word, 0);

        // Three-stage synchroniser instance
        access(1'b0, 1'b0, 4'hA, 8'hFF, 8, n_wr, n_rd, n_word, at2, at3, bd4);
        chk("sync3_latency", at3, 3);
        chk("sync3_capture", {rn3, db3}, {4'hA, 8'hFF});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
